// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int WAIT_CNT_W      = 4;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_WAIT_STATES = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Request as seen by the responder, latched at accept
  typedef struct packed {
    logic                    write;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic [WORD_BYTES-1:0]   be;
    logic                    err;
  } req_t;

  // Misaligned, or outside the 2^aw-word window
  function automatic logic addr_bad(input logic [31:0] addr, input int aw);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (aw + 2)) - 32'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-enabled synchronous word RAM; read-before-write on the same edge, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed wait states.
// Optional address rejection is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_t                state, state_nx;
  logic [WAIT_CNT_W-1:0] cnt;
  req_t                  req_q, req_cur;
  logic                  accept, enter_resp, in_err, arr_we;
  logic                  rd_sel;
  logic [31:0]           arr_rdata, rdata_q;

  assign accept = bus.req_valid && (state == IDLE);

`ifdef DMEM_ERR_CHECK_EN
  assign in_err = addr_bad(bus.req_addr, ADDR_WIDTH);
`else
  assign in_err = 1'b0;
`endif

  // With zero wait states the array is accessed on the accept edge itself,
  // so the live request is used while idle and the latched one afterwards.
  always_comb begin
    req_cur = req_q;
    if (state == IDLE) begin
      req_cur = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata,
                  be: bus.req_be, err: in_err};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP);
  assign arr_we     = enter_resp && req_cur.write && !req_cur.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rd_sel  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_nx;
      if (accept) begin
        req_q <= req_cur;
        cnt   <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      rd_sel <= enter_resp && !req_cur.write && !req_cur.err;
      if (rd_sel) rdata_q <= arr_rdata;
    end
  end

  dmem_array #(.AW(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (req_cur.be),
    .addr  (req_cur.addr[ADDR_WIDTH+1:2]),
    .wdata (req_cur.wdata),
    .rdata (arr_rdata)
  );

  // The array register carries a fresh load during RESP; the hold register
  // keeps that word afterwards so later array reads never disturb it.
  assign bus.rsp_rdata = rd_sel ? arr_rdata : rdata_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            err_q <= 1'b0;
    else if (enter_resp) err_q <= req_cur.err;
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_q.addr[31:ADDR_WIDTH+2], req_q.addr[1:0],
                              req_cur.addr[31:ADDR_WIDTH+2], req_cur.addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_STATES=2, ADDR_WIDTH=8).
module tb_dmem_responder;

  localparam int WS = 2;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc_last, rsp_last;

  dmem_responder_if bus ();

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the idle negedge after the response.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rd, output logic er);
    int acc, rsp;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin acc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    // Scramble inputs: only the accept-time values may matter
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_addr  = 32'h0000_0004;
    bus.req_wdata = 32'h0BAD_0BAD;
    bus.req_be    = 4'hF;
    rsp = -1;
    rd  = '0;
    er  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk({tag, "_rdy_low"}, bus.req_ready, 1'b0);
      if (bus.rsp_valid) begin
        rsp = cyc; rd = bus.rsp_rdata; er = bus.rsp_err;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_lat"}, rsp - acc, WS + 1);
    @(negedge clk);
    chk({tag, "_strobe"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rdy_back"}, bus.req_ready, 1'b1);
    acc_last = acc;
    rsp_last = rsp;
  endtask

  logic [31:0] rd;
  logic        er;
  logic        saw;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_busy",  bus.busy, 1'b0);
    chk("rst_rspv",  bus.rsp_valid, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_err",   bus.rsp_err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.req_ready, 1'b1);
    chk("rel_busy",  bus.busy, 1'b0);
    for (int i = 0; i < 20 && cyc < 5; i++) @(negedge clk);

    // Store accepted in cycle 5 responds in cycle 8
    xact("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er);
    chk("st10_acc_cyc", acc_last, 5);
    chk("st10_rsp_cyc", rsp_last, 8);
    chk("st10_err", er, 1'b0);
    xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("ld10_data", rd, 32'hDEAD_BEEF);

    // Byte enables
    xact("st20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er);
    xact("st20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er);
    chk("rdata_hold", bus.rsp_rdata, 32'hDEAD_BEEF);
    xact("ld20", 1'b0, 32'h20, 32'h0, 4'hF, rd, er);
    chk("ld20_data", rd, 32'h11BB_33DD);
    xact("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, rd, er);
    xact("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    chk("ld20z_data", rd, 32'h11BB_33DD);

    // req_valid held high: accept every WS+2 cycles
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h10;
    bus.req_be    = 4'h0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("hold_rdy%0d", i), bus.req_ready, (i % (WS + 2)) == 0);
      chk($sformatf("hold_rsp%0d", i), bus.rsp_valid, (i % (WS + 2)) == WS + 1);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (WS + 2) @(negedge clk);
    chk("hold_data", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("hold_idle", bus.req_ready, 1'b1);

    // Reset during WAIT drops a pending store
    xact("st30", 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, rd, er);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h1234_5678;
    bus.req_be    = 4'hF;
    chk("mr_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mr_in_wait", bus.busy, 1'b1);
    rst = 1'b0;
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw |= bus.rsp_valid; end
    rst = 1'b1;
    repeat (5) begin @(negedge clk); saw |= bus.rsp_valid; end
    chk("mr_no_rsp", saw, 1'b0);
    chk("mr_rdata_rst", bus.rsp_rdata, 32'h0);
    xact("ld30", 1'b0, 32'h30, 32'h0, 4'h0, rd, er);
    chk("ld30_data", rd, 32'hCAFE_F00D);

    // Misaligned / out-of-window accesses
    xact("st13", 1'b1, 32'h13, 32'h5566_7788, 4'hF, rd, er);
    chk("st13_err", er, ERR_EN);
    xact("ld10b", 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("ld10b_data", rd, ERR_EN ? 32'hDEAD_BEEF : 32'h5566_7788);
    xact("ld410", 1'b0, 32'h410, 32'h0, 4'h0, rd, er);
    chk("ld410_err", er, ERR_EN);
    chk("ld410_data", rd, ERR_EN ? 32'hDEAD_BEEF : 32'h5566_7788);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the target side of the MEM stage's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a fixed number of wait states. Stores use per-byte write enables; loads return a full word with a one-cycle response strobe. It replaces the single-cycle data memory so the pipeline can be exercised against realistic memory latency. The MEM stage stalls while `req_ready` is low or a response is outstanding.

## Interface
- `ADDR_WIDTH`, 8: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 2: idle cycles between accept and response; legal range 0–15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address from the ALU result.
- `req_wdata` input 32: store data.
- `req_be` input 4: byte enables; bit i covers `req_wdata[8i+7:8i]`.
- `rsp_valid` output 1: one-cycle response strobe for both loads and stores.
- `rsp_rdata` output 32: load data; holds its value until the next load response.
- `rsp_err` output 1: request rejected; valid while `rsp_valid` is high.
- `busy` output 1: request accepted and not yet responded to.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch write, addr, wdata and be, then go to WAIT. If WAIT_STATES=0, go directly to RESP.
  - WAIT: 4-bit down-counter loaded with WAIT_STATES−1 at accept. When the count reaches 0, go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then return to IDLE unconditionally.
- Memory access happens on the clock edge that enters RESP:
  - Store: write the enabled bytes only.
  - Load: capture the full word into `rsp_rdata`. `req_be` is ignored for loads.
- Word index is `req_addr[ADDR_WIDTH+1:2]`.
- `busy` = state is WAIT or RESP. `req_ready` = state is IDLE.
- No back-to-back accept: the earliest next accept is the cycle after RESP.
- Inputs are sampled only at accept, so changes during WAIT have no effect.
- A store with `req_be`=0 completes with a response and leaves memory unchanged.
- Reset values:
  - State IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; `busy`=0; counter=0.
  - Memory array contents are not reset.
- Reset during WAIT: the request is dropped, the pending store is never committed, and no response is issued.

## Timing
- Accept on edge N (`req_valid` & `req_ready`). `rsp_valid` is high during cycle N+WAIT_STATES+1.
  - WAIT_STATES=0: response is in the cycle after accept.
  - WAIT_STATES=2: response is 3 cycles after accept.
- Throughput: one request per WAIT_STATES+2 cycles.
- `rsp_rdata` and `rsp_err` are registered and change only on the edge entering RESP.
- `req_ready` is a registered-state decode with no combinational path from `req_valid`.

## Configuration
- `DMEM_ERR_CHECK_EN` defined:
  - A request is rejected if `req_addr[1:0]`≠0 or `req_addr[31:ADDR_WIDTH+2]`≠0.
  - Rejected requests respond at normal latency with `rsp_err`=1.
  - A rejected store writes nothing; a rejected load leaves `rsp_rdata` unchanged.
- `DMEM_ERR_CHECK_EN` undefined:
  - Address bits outside `[ADDR_WIDTH+1:2]` are ignored, so accesses alias.
  - `rsp_err` is tied to 0.

## Structure
- `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - `WORD_BYTES`=4;
  - `WAIT_CNT_W`=4;
  - default `ADDR_WIDTH` and `WAIT_STATES` constants.
- One sub-module, `dmem_array`:
  - byte-enabled synchronous RAM with port (clk, we, be[3:0], addr, wdata, rdata);
  - read-before-write on the same edge; no reset.
- FSM, counter and error check live in `dmem_responder`.

## Test plan
- Reset, then release `rst`:
  - `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_rdata`=0.
- WAIT_STATES=2, store 0xDEADBEEF to 0x10 with be=4'hF accepted on cycle 5, then load 0x10:
  - store `rsp_valid` in cycle 8;
  - load `rsp_rdata`=0xDEADBEEF exactly 3 cycles after its accept.
- Byte enables:
  - store 0x11223344 to 0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101;
  - load 0x20 returns 0x11BB33DD.
- Hold `req_valid` high continuously:
  - accepts are spaced exactly WAIT_STATES+2 cycles apart;
  - `req_ready`=0 throughout WAIT and RESP.
- Reset mid-operation:
  - store 0x12345678 to 0x30, assert `rst` during WAIT;
  - no `rsp_valid` is issued and a subsequent load of 0x30 returns the prior contents.
- With `DMEM_ERR_CHECK_EN`, store to 0x13 (misaligned):
  - `rsp_err`=1 with `rsp_valid`;
  - a load of 0x10 shows the word unchanged.
- Without `DMEM_ERR_CHECK_EN`, same store:
  - `rsp_err`=0 and the word at 0x10 is written.
